pipelined_multiplier: RTL and testbench

- Unsigned SIZE x SIZE integer multiplier, fully pipelined: accepts a new operand pair every clock and produces the 2*SIZE-bit product a fixed 4 cycles later.
- Datapath arithmetic block with no handshake in the base configuration. The instantiating logic tracks data validity by counting cycles.
- Structure: partial-product generation, then a registered binary adder tree.

---
 rtl/mult_pkg.sv | 35 +++
 rtl/mult_add_stage.sv | 35 +++
 rtl/pipelined_multiplier.sv | 92 +++++++++
 tb/tb_pipelined_multiplier.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the pipelined unsigned multiplier.
//   MULT_SIZE_DEF : default operand width
//   clog2()       : elaboration-time ceil(log2)
//   mult_latency(): register stages from operand sample to y_out
//   LATENCY_DEF   : latency for the default width
//   prod_t        : product word for the default width
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_SIZE_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // One partial-product stage plus one register per adder-tree level.
  function automatic int mult_latency(input int size);
    return 1 + clog2(size);
  endfunction

  localparam int LATENCY_DEF = mult_latency(MULT_SIZE_DEF);

  typedef logic [2*MULT_SIZE_DEF-1:0] prod_t;

endpackage

// File: rtl/mult_add_stage.sv
// -----------------------------------------------------------------------------
// mult_add_stage
// One registered level of the adder tree: N inputs summed pairwise into N/2
// registered outputs.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears all outputs
//   i_d  : N input words, W bits each
//   o_q  : N/2 registered sums, o_q[k] = i_d[2k] + i_d[2k+1]
// -----------------------------------------------------------------------------
module mult_add_stage #(
  parameter int N = 2,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0][W-1:0]    i_d,
  output logic [N/2-1:0][W-1:0]  o_q
);

  logic [N/2-1:0][W-1:0] r_q;

  // Words are already full product width, so no carry can be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      for (int k = 0; k < N/2; k++) begin
        r_q[k] <= i_d[2*k] + i_d[2*k+1];
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// -----------------------------------------------------------------------------
// pipelined_multiplier
// Unsigned SIZE x SIZE multiplier, one operand pair per clock, product on
// y_out LATENCY (= 1 + log2(SIZE), 4 for SIZE=8) rising edges after sampling.
// Stage 1 registers shifted partial products; each later stage is one level
// of a registered pairwise adder tree.
//   a_in      : multiplicand (SIZE bits, unsigned)
//   b_in      : multiplier   (SIZE bits, unsigned)
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset, flushes every stage
//   y_out     : registered product (2*SIZE bits)
// Optional (macro PIPELINED_MULTIPLIER_VALID_EN):
//   in_valid  : qualifies a_in/b_in
//   out_valid : high when y_out carries a product of an in_valid=1 sample
// SIZE must be a power of two and >= 4.
// -----------------------------------------------------------------------------
module pipelined_multiplier
  import mult_pkg::*;
#(
  parameter int SIZE = MULT_SIZE_DEF
) (
  input  logic [SIZE-1:0]   a_in,
  input  logic [SIZE-1:0]   b_in,
  input  logic              clk,
  input  logic              rst,
  output logic [2*SIZE-1:0] y_out
`ifdef PIPELINED_MULTIPLIER_VALID_EN
  ,
  input  logic              in_valid,
  output logic              out_valid
`endif
);

  localparam int PW      = 2 * SIZE;
  localparam int LATENCY = mult_latency(SIZE);
  localparam int LVLS    = LATENCY - 1;   // adder-tree levels

  // All tree nodes in one flat array: level l occupies SIZE>>l words
  // starting at 2*SIZE - 2*(SIZE>>l); the root is the last word.
  logic [2*SIZE-2:0][PW-1:0] w_tree;
  logic [SIZE-1:0][PW-1:0]   r_pp;

  // Stage 1: partial products, zero-extended then shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pp <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        r_pp[i] <= b_in[i] ? (PW'(a_in) << i) : '0;
      end
    end
  end

  assign w_tree[SIZE-1:0] = r_pp;

  genvar l;
  generate
    for (l = 0; l < LVLS; l++) begin : g_lvl
      localparam int NIN    = SIZE >> l;
      localparam int IN_OFF = 2*SIZE - 2*NIN;
      localparam int OUT_OFF = IN_OFF + NIN;

      mult_add_stage #(
        .N (NIN),
        .W (PW)
      ) u_add (
        .clk (clk),
        .rst (rst),
        .i_d (w_tree[IN_OFF +: NIN]),
        .o_q (w_tree[OUT_OFF +: NIN/2])
      );
    end
  endgenerate

  assign y_out = w_tree[2*SIZE-2];

`ifdef PIPELINED_MULTIPLIER_VALID_EN
  // Valid shadows the data path stage for stage; data registers never stall.
  logic [LATENCY:1] r_vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LATENCY-1:1], in_valid};
    end
  end

  assign out_valid = r_vld_pipe[LATENCY];
`endif

endmodule

// File: tb/tb_pipelined_multiplier.sv
module tb_pipelined_multiplier;

  localparam int SIZE = 8;
  localparam int LAT  = 4;

  typedef struct {
    logic        v;
    logic [15:0] p;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [SIZE-1:0]   a_in;
  logic [SIZE-1:0]   b_in;
  logic [2*SIZE-1:0] y_out;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
  logic              in_valid;
  logic              out_valid;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  pipelined_multiplier #(.SIZE(SIZE)) dut (
    .a_in      (a_in),
    .b_in      (b_in),
    .clk       (clk),
    .rst       (rst),
    .y_out     (y_out)
`ifdef PIPELINED_MULTIPLIER_VALID_EN
    ,
    .in_valid  (in_valid),
    .out_valid (out_valid)
`endif
  );

  // Drive on the falling edge, model the rising edge, check 1 time unit later.
  task automatic step(input logic [7:0] a, input logic [7:0] b,
                      input logic r, input logic v);
    exp_t e;
    @(negedge clk);
    a_in = a;
    b_in = b;
    rst  = r;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
    in_valid = v;
`endif
    @(posedge clk);
    if (r) begin
      q.delete();
      for (int k = 0; k < LAT; k++) q.push_back('{1'b0, 16'd0});
    end else begin
      e.v = v;
      e.p = {8'd0, a} * {8'd0, b};
      q.push_back(e);
      if (q.size() > LAT) void'(q.pop_front());
    end
    #1;
    if (q.size() == LAT) begin
      checks++;
      assert (y_out === q[0].p) else begin
        errors++;
        $error("FAIL y_out: got %0d expected %0d", y_out, q[0].p);
      end
`ifdef PIPELINED_MULTIPLIER_VALID_EN
      checks++;
      assert (out_valid === q[0].v) else begin
        errors++;
        $error("FAIL out_valid: got %0b expected %0b", out_valid, q[0].v);
      end
`endif
    end
  endtask

  initial begin
    rst  = 1'b1;
    a_in = '0;
    b_in = '0;
`ifdef PIPELINED_MULTIPLIER_VALID_EN
    in_valid = 1'b0;
`endif

    // Reset held with max operands: output stays 0.
    for (int i = 0; i < 3; i++) step(8'd255, 8'd255, 1'b1, 1'b1);
    checks++;
    assert (y_out === 16'd0) else begin
      errors++;
      $error("FAIL reset_state: got %0d expected 0", y_out);
    end
    // Release: 65025 arrives after four sampled edges.
    for (int i = 0; i < 4; i++) step(8'd255, 8'd255, 1'b0, 1'b1);
    checks++;
    assert (y_out === 16'd65025) else begin
      errors++;
      $error("FAIL first_after_reset: got %0d expected 65025", y_out);
    end

    // Streaming.
    for (int i = 0; i < 6; i++)
      step(8'(2*i+1), 8'(2*i+2), 1'b0, 1'b1);

    // Corners, then flush so each is seen at latency.
    step(8'd0,   8'd200, 1'b0, 1'b1);
    step(8'd200, 8'd0,   1'b0, 1'b1);
    step(8'd255, 8'd1,   1'b0, 1'b1);
    step(8'd128, 8'd128, 1'b0, 1'b1);
    step(8'd255, 8'd255, 1'b0, 1'b1);
    for (int i = 0; i < LAT; i++) step(8'd0, 8'd0, 1'b0, 1'b1);

    // Constant inputs give a constant output.
    for (int i = 0; i < 8; i++) step(8'd17, 8'd3, 1'b0, 1'b1);
    checks++;
    assert (y_out === 16'd51) else begin
      errors++;
      $error("FAIL hold_const: got %0d expected 51", y_out);
    end

    // Mid-stream reset flushes in-flight products.
    step(8'd10, 8'd10, 1'b0, 1'b1);
    step(8'd20, 8'd20, 1'b0, 1'b1);
    step(8'd0,  8'd0,  1'b1, 1'b1);
    for (int i = 0; i < LAT + 1; i++) begin
      step(8'd0, 8'd0, 1'b0, 1'b0);
      checks++;
      assert (y_out !== 16'd100 && y_out !== 16'd400) else begin
        errors++;
        $error("FAIL flush: got %0d expected neither 100 nor 400", y_out);
      end
    end

`ifdef PIPELINED_MULTIPLIER_VALID_EN
    // Valid gaps travel with the data.
    step(8'd3, 8'd3, 1'b0, 1'b1);
    step(8'd4, 8'd4, 1'b0, 1'b0);
    step(8'd5, 8'd5, 1'b0, 1'b1);
    for (int i = 0; i < LAT; i++) step(8'd0, 8'd0, 1'b0, 1'b0);
`endif

    // Random back-to-back traffic.
    for (int i = 0; i < 1000; i++)
      step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0,
           1'($urandom_range(0, 1)));
    for (int i = 0; i < LAT; i++) step(8'd0, 8'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
